// File: rtl/oflow_buffer_write_sched.sv
// Buffer-side write scheduler: queues bbox groups from the core and serialises them into MEM buffer writes.
// Optional OFLOW_WR_PARITY_EN appends an even-parity MSB to every write word.
module oflow_buffer_write_sched #(
    parameter int PE_NUM = 24,
    parameter int ROW_W  = 5,
    parameter int PE_W   = 5,
    parameter int BBOX_W = 64,
    parameter int ADDR_W = 10,
    parameter int QDEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset_N,
    input  logic                  i_start_frame,
    input  logic [ADDR_W-1:0]     i_num_bbox_expected,
    input  logic                  i_ready_from_core,
    input  logic [1:0]            i_remainder,
    input  logic [ROW_W-1:0]      i_row_sel,
    input  logic [PE_W-1:0]       i_pe_sel,
    input  logic [4*BBOX_W-1:0]   i_group_data,
    output logic                  o_mem_we,
    output logic [ADDR_W-1:0]     o_mem_addr,
`ifdef OFLOW_WR_PARITY_EN
    output logic [BBOX_W:0]       o_mem_wdata,
`else
    output logic [BBOX_W-1:0]     o_mem_wdata,
`endif
    output logic                  o_done_write_buffer,
    output logic                  o_frame_done,
    output logic                  o_busy,
    output logic                  o_overflow_err,
    output logic [ADDR_W-1:0]     o_wr_count
);

    localparam int PTR_W = $clog2(QDEPTH);

    typedef enum logic {IDLE, WRITE} state_t;

    state_t                r_state;
    state_t                w_stateNext;

    logic [ROW_W-1:0]      r_qRow  [QDEPTH];
    logic [PE_W-1:0]       r_qPe   [QDEPTH];
    logic [1:0]            r_qRem  [QDEPTH];
    logic [4*BBOX_W-1:0]   r_qData [QDEPTH];
    logic [PTR_W-1:0]      r_wrPtr;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [PTR_W:0]        r_qCount;

    logic [ADDR_W-1:0]     r_curBase;
    logic [1:0]            r_curLast;
    logic [4*BBOX_W-1:0]   r_curData;
    logic [1:0]            r_lane;
    logic [ADDR_W-1:0]     r_expected;
    logic                  r_frameFired;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_lastLane;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    logic [PTR_W:0]        w_countNext;
    logic [ADDR_W-1:0]     w_headBase;
    logic [1:0]            w_headLast;
    logic                  w_writeNext;
    logic                  w_doneNext;
    logic [4*BBOX_W-1:0]   w_srcData;
    logic [ADDR_W-1:0]     w_srcBase;
    logic [1:0]            w_nextLane;
    logic [BBOX_W-1:0]     w_laneData;

    assign w_empty    = (r_qCount == '0);
    assign w_full     = (r_qCount == (PTR_W+1)'(QDEPTH));
    assign w_lastLane = (r_lane == r_curLast);

    // remainder 0 means four lanes, so the last lane index is simply remainder-1 modulo 4
    assign w_headLast = 2'(r_qRem[r_rdPtr] - 2'd1);
    assign w_headBase = ADDR_W'(32'(r_qRow[r_rdPtr]) * PE_NUM + 32'(r_qPe[r_rdPtr]) * 32'd4);

    always_comb begin
        w_stateNext = r_state;
        w_pop       = 1'b0;
        if (i_start_frame) begin
            w_stateNext = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_stateNext = WRITE;
                    end
                end
                WRITE: begin
                    if (w_lastLane) begin
                        if (!w_empty) w_pop = 1'b1;
                        else          w_stateNext = IDLE;
                    end
                end
                default: w_stateNext = IDLE;
            endcase
        end
    end

    always_comb begin
        w_push      = i_ready_from_core && !i_start_frame && (!w_full || w_pop);
        w_drop      = i_ready_from_core && !i_start_frame && w_full && !w_pop;
        w_countNext = r_qCount;
        if (i_start_frame)         w_countNext = '0;
        else if (w_push && !w_pop) w_countNext = r_qCount + (PTR_W+1)'(1);
        else if (w_pop && !w_push) w_countNext = r_qCount - (PTR_W+1)'(1);
        w_writeNext = w_pop || (r_state == WRITE && !w_lastLane && !i_start_frame);
        w_doneNext  = (r_state == WRITE) && w_lastLane && !i_start_frame;
        w_srcData   = w_pop ? r_qData[r_rdPtr] : r_curData;
        w_srcBase   = w_pop ? w_headBase : r_curBase;
        w_nextLane  = w_pop ? 2'd0 : r_lane + 2'd1;
        w_laneData  = w_srcData[32'(w_nextLane) * BBOX_W +: BBOX_W];
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_qRow[r_wrPtr]  <= i_row_sel;
            r_qPe[r_wrPtr]   <= i_pe_sel;
            r_qRem[r_wrPtr]  <= i_remainder;
            r_qData[r_wrPtr] <= i_group_data;
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            r_state             <= IDLE;
            r_wrPtr             <= '0;
            r_rdPtr             <= '0;
            r_qCount            <= '0;
            r_curBase           <= '0;
            r_curLast           <= '0;
            r_curData           <= '0;
            r_lane              <= '0;
            r_expected          <= '0;
            r_frameFired        <= 1'b0;
            o_mem_we            <= 1'b0;
            o_mem_addr          <= '0;
            o_mem_wdata         <= '0;
            o_done_write_buffer <= 1'b0;
            o_frame_done        <= 1'b0;
            o_busy              <= 1'b0;
            o_overflow_err      <= 1'b0;
            o_wr_count          <= '0;
        end else begin
            r_state             <= w_stateNext;
            r_qCount            <= w_countNext;
            o_mem_we            <= w_writeNext;
            o_done_write_buffer <= w_doneNext;
            o_busy              <= (w_countNext != '0) || (w_stateNext == WRITE);

            if (i_start_frame) begin
                r_wrPtr <= '0;
                r_rdPtr <= '0;
            end else begin
                if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
                if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
            end

            if (w_pop) begin
                r_curBase <= w_headBase;
                r_curLast <= w_headLast;
                r_curData <= r_qData[r_rdPtr];
            end

            if (w_writeNext) begin
                r_lane     <= w_nextLane;
                o_mem_addr <= w_srcBase + ADDR_W'(w_nextLane);
`ifdef OFLOW_WR_PARITY_EN
                o_mem_wdata <= {^w_laneData, w_laneData};
`else
                o_mem_wdata <= w_laneData;
`endif
            end

            // frame_done is derived from the registered count, so it trails the final write by two cycles
            if (i_start_frame) begin
                r_expected     <= i_num_bbox_expected;
                r_frameFired   <= 1'b0;
                o_frame_done   <= 1'b0;
                o_wr_count     <= '0;
                o_overflow_err <= 1'b0;
            end else begin
                o_wr_count <= o_wr_count + ADDR_W'(o_mem_we);
                if (w_drop) o_overflow_err <= 1'b1;
                if (!r_frameFired && r_expected != '0 && o_wr_count == r_expected) begin
                    o_frame_done <= 1'b1;
                    r_frameFired <= 1'b1;
                end else begin
                    o_frame_done <= 1'b0;
                end
            end
        end
    end

endmodule
